// File: rtl/eic_vectored.sv
// Vectored external interrupt controller: per-channel sense mode and mask,
// pending latch with software set/clear, and fixed-priority arbitration
// (highest channel index wins) onto the MIPS EIC port with an acknowledge
// handshake. Optional macro EIC_SYNC_EN inserts a 2-flop synchroniser per
// input bit and lengthens the post-reset warm-up to match.
module eic_vectored #(
    parameter int unsigned CHANNELS = 16
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [CHANNELS-1:0] signal,
    input  logic                cfg_we,
    input  logic [7:0]          cfg_ch,
    input  logic                cfg_mask,
    input  logic [1:0]          cfg_sense,
    input  logic                sw_we,
    input  logic [7:0]          sw_ch,
    input  logic                sw_val,
    input  logic                EIC_IAck,
    output logic [CHANNELS-1:0] pending,
    output logic [7:0]          EIC_Interrupt,
    output logic [5:0]          EIC_Vector,
    output logic [16:0]         EIC_Offset,
    output logic [3:0]          EIC_ShadowSet
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

`ifdef EIC_SYNC_EN
    localparam logic [2:0] WARMUP = 3'd4;
`else
    localparam logic [2:0] WARMUP = 3'd2;
`endif

    logic [CHANNELS-1:0]      sampled;
    logic [CHANNELS-1:0]      hist_new_q;
    logic [CHANNELS-1:0]      hist_old_q;
    logic [2:0]               warm_q;
    logic [CHANNELS-1:0]      mask_q;
    logic [CHANNELS-1:0][1:0] sense_q;
    logic [CHANNELS-1:0]      ev;
    logic [CHANNELS-1:0]      pending_q, pending_d;
    logic [CHANNELS-1:0]      req;
    logic [7:0]               win;
    logic [7:0]               int_q, int_d;
    state_t                   state_q, state_d;
    logic                     ack_hit;
    logic [7:0]               ack_ch;

`ifdef EIC_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser for asynchronous interrupt sources
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= signal;
            sync2_q <= sync1_q;
        end
    end

    assign sampled = sync2_q;
`else
    assign sampled = signal;
`endif

    // Sample history and warm-up countdown after reset
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            hist_new_q <= '0;
            hist_old_q <= '0;
            warm_q     <= WARMUP;
        end else begin
            hist_new_q <= sampled;
            hist_old_q <= hist_new_q;
            if (warm_q != 3'd0) warm_q <= warm_q - 3'd1;
        end
    end

    // Per-channel configuration registers; out-of-range channels match nothing
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mask_q  <= '0;
            sense_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (cfg_we && cfg_ch == 8'(i)) begin
                    mask_q[i]  <= cfg_mask;
                    sense_q[i] <= cfg_sense;
                end
            end
        end
    end

    // Sense-mode event decode, suppressed until the history holds real samples
    always_comb begin
        ev = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            case (sense_q[i])
                2'b00:   ev[i] = ~hist_old_q[i] & ~hist_new_q[i];
                2'b01:   ev[i] =  hist_old_q[i] ^  hist_new_q[i];
                2'b10:   ev[i] =  hist_old_q[i] & ~hist_new_q[i];
                default: ev[i] = ~hist_old_q[i] &  hist_new_q[i];
            endcase
        end
        if (warm_q != 3'd0) ev = '0;
    end

    assign ack_hit = (state_q == PRESENT) && EIC_IAck;
    assign ack_ch  = int_q - 8'd1;

    // Pending update: level follows the event; edge latches with sw/ack
    // applied first and a new edge ORed in last so it is never lost
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sense_q[i] == 2'b00) begin
                pending_d[i] = ev[i];
            end else begin
                if (sw_we && sw_ch == 8'(i))
                    pending_d[i] = sw_val;
                else if (ack_hit && ack_ch == 8'(i))
                    pending_d[i] = 1'b0;
                pending_d[i] = pending_d[i] | ev[i];
            end
            if (cfg_we && cfg_ch == 8'(i) && cfg_sense != sense_q[i])
                pending_d[i] = 1'b0;
        end
    end

    // Pending flags
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign req = pending_q & mask_q;

    // Fixed priority: the highest-index active request wins
    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (req[i]) win = 8'(i);
        end
    end

    // Presentation FSM next state and registered vector
    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    int_d   = win + 8'd1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (EIC_IAck) begin
                    int_d   = '0;
                    state_d = HOLD;
                end else if (req == '0) begin
                    int_d   = '0;
                    state_d = IDLE;
                end else begin
                    int_d   = win + 8'd1;
                end
            end
            HOLD: begin
                int_d   = '0;
                state_d = IDLE;
            end
            default: begin
                int_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and vector registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            int_q   <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
        end
    end

    assign pending       = pending_q;
    assign EIC_Interrupt = int_q;
    assign EIC_Vector    = int_q[5:0];
    assign EIC_Offset    = '0;
    assign EIC_ShadowSet = '0;

endmodule

// File: tb/tb_eic_vectored.sv
// Directed self-checking bench for eic_vectored (default build, 16 channels).
module tb_eic_vectored;

    logic        CLK;
    logic        RESETn;
    logic [15:0] signal;
    logic        cfg_we;
    logic [7:0]  cfg_ch;
    logic        cfg_mask;
    logic [1:0]  cfg_sense;
    logic        sw_we;
    logic [7:0]  sw_ch;
    logic        sw_val;
    logic        EIC_IAck;
    logic [15:0] pending;
    logic [7:0]  EIC_Interrupt;
    logic [5:0]  EIC_Vector;
    logic [16:0] EIC_Offset;
    logic [3:0]  EIC_ShadowSet;

    int checks = 0;
    int errors = 0;

    eic_vectored #(.CHANNELS(16)) dut (
        .CLK(CLK), .RESETn(RESETn), .signal(signal),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask), .cfg_sense(cfg_sense),
        .sw_we(sw_we), .sw_ch(sw_ch), .sw_val(sw_val), .EIC_IAck(EIC_IAck),
        .pending(pending), .EIC_Interrupt(EIC_Interrupt), .EIC_Vector(EIC_Vector),
        .EIC_Offset(EIC_Offset), .EIC_ShadowSet(EIC_ShadowSet)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [7:0] ch, input logic m, input logic [1:0] s);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mask = m; cfg_sense = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic ack();
        EIC_IAck = 1'b1;
        tick();
        EIC_IAck = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL rst_int got %0d want 0", EIC_Interrupt); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL rst_pend got %h want 0000", pending); end
        checks++; if (EIC_Offset !== 17'd0 || EIC_ShadowSet !== 4'd0) begin errors++; $display("FAIL rst_const got %h/%h want 0/0", EIC_Offset, EIC_ShadowSet); end
        RESETn = 1'b1;
        tick();
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL warm1_pend got %h want 0000", pending); end
        tick();
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL warm2_pend got %h want 0000", pending); end
        tick();
        // all channels in low-level mode with inputs low, but none enabled
        checks++; if (pending !== 16'hFFFF) begin errors++; $display("FAIL level_all got %h want ffff", pending); end
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL masked_int got %0d want 0", EIC_Interrupt); end
    endtask

    task automatic test_rise_ack();
        cfg(8'd3, 1'b1, 2'b11);
        checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL cfg_clear got %b want 0", pending[3]); end
        signal[3] = 1'b1;
        tick();
        checks++; if (pending[3] !== 1'b0 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL e0 got %b/%0d want 0/0", pending[3], EIC_Interrupt); end
        tick();
        checks++; if (pending[3] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL e1 got %b/%0d want 1/0", pending[3], EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd4 || EIC_Vector !== 6'd4) begin errors++; $display("FAIL e2 got %0d/%0d want 4/4", EIC_Interrupt, EIC_Vector); end
        signal[3] = 1'b0;
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd4) begin errors++; $display("FAIL hold4 got %0d want 4", EIC_Interrupt); end
        ack();
        checks++; if (pending[3] !== 1'b0 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL ack3 got %b/%0d want 0/0", pending[3], EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL hold_st got %0d want 0", EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL idle3 got %0d want 0", EIC_Interrupt); end
    endtask

    task automatic test_priority();
        signal[9] = 1'b1;
        tick(); tick();
        cfg(8'd2, 1'b1, 2'b11);
        cfg(8'd9, 1'b1, 2'b10);
        signal[2] = 1'b1; signal[9] = 1'b0;
        tick(); tick();
        checks++; if (pending[2] !== 1'b1 || pending[9] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL pri_e1 got %b%b/%0d want 11/0", pending[9], pending[2], EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd10) begin errors++; $display("FAIL pri_win got %0d want 10", EIC_Interrupt); end
        ack();
        checks++; if (pending[9] !== 1'b0 || pending[2] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL pri_ack got %b%b/%0d want 01/0", pending[9], pending[2], EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL pri_hold got %0d want 0", EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd3) begin errors++; $display("FAIL pri_next got %0d want 3", EIC_Interrupt); end
        ack();
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd0 || pending[2] !== 1'b0) begin errors++; $display("FAIL pri_done got %0d/%b want 0/0", EIC_Interrupt, pending[2]); end
    endtask

    task automatic test_level();
        cfg(8'd5, 1'b1, 2'b00);
        tick();
        checks++; if (EIC_Interrupt !== 8'd6) begin errors++; $display("FAIL lvl_int got %0d want 6", EIC_Interrupt); end
        ack();
        checks++; if (pending[5] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL lvl_ack got %b/%0d want 1/0", pending[5], EIC_Interrupt); end
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd6) begin errors++; $display("FAIL lvl_re got %0d want 6", EIC_Interrupt); end
        signal[5] = 1'b1;
        tick(); tick();
        checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL lvl_drop got %b want 0", pending[5]); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL lvl_off got %0d want 0", EIC_Interrupt); end
    endtask

    task automatic test_preempt();
        cfg(8'd1, 1'b1, 2'b11);
        cfg(8'd7, 1'b1, 2'b11);
        signal[1] = 1'b1;
        tick(); tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd2) begin errors++; $display("FAIL pre_ch1 got %0d want 2", EIC_Interrupt); end
        signal[7] = 1'b1;
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd2) begin errors++; $display("FAIL pre_e1 got %0d want 2", EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd8 || pending[1] !== 1'b1) begin errors++; $display("FAIL pre_win got %0d/%b want 8/1", EIC_Interrupt, pending[1]); end
        ack();
        checks++; if (pending[7] !== 1'b0 || pending[1] !== 1'b1) begin errors++; $display("FAIL pre_ack got %b%b want 01", pending[7], pending[1]); end
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd2) begin errors++; $display("FAIL pre_back got %0d want 2", EIC_Interrupt); end
        ack();
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd0 || pending[1] !== 1'b0) begin errors++; $display("FAIL pre_done got %0d/%b want 0/0", EIC_Interrupt, pending[1]); end
    endtask

    task automatic test_ack_race();
        cfg(8'd4, 1'b1, 2'b11);
        signal[4] = 1'b1;
        tick(); tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd5) begin errors++; $display("FAIL race_pres got %0d want 5", EIC_Interrupt); end
        signal[4] = 1'b0;
        tick(); tick();
        signal[4] = 1'b1;
        tick();
        ack();
        checks++; if (pending[4] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL race_keep got %b/%0d want 1/0", pending[4], EIC_Interrupt); end
        tick(); tick();
        checks++; if (EIC_Interrupt !== 8'd5) begin errors++; $display("FAIL race_re got %0d want 5", EIC_Interrupt); end
        sw_we = 1'b1; sw_ch = 8'd4; sw_val = 1'b0;
        tick();
        sw_we = 1'b0;
        checks++; if (pending[4] !== 1'b0) begin errors++; $display("FAIL sw_clr got %b want 0", pending[4]); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL sw_clr_int got %0d want 0", EIC_Interrupt); end
    endtask

    task automatic test_sw();
        sw_we = 1'b1; sw_ch = 8'd200; sw_val = 1'b1;
        tick();
        sw_we = 1'b0;
        checks++; if (pending !== 16'hFD41) begin errors++; $display("FAIL sw_oor got %h want fd41", pending); end
        sw_we = 1'b1; sw_ch = 8'd4; sw_val = 1'b1;
        tick();
        sw_we = 1'b0;
        checks++; if (pending[4] !== 1'b1 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL sw_set got %b/%0d want 1/0", pending[4], EIC_Interrupt); end
        tick();
        checks++; if (EIC_Interrupt !== 8'd5) begin errors++; $display("FAIL sw_int got %0d want 5", EIC_Interrupt); end
    endtask

    task automatic test_async_reset();
        RESETn = 1'b0;
        #1;
        checks++; if (EIC_Interrupt !== 8'd0 || pending !== 16'h0) begin errors++; $display("FAIL arst got %0d/%h want 0/0000", EIC_Interrupt, pending); end
        signal = 16'hFFFF;
        tick(); tick();
        RESETn = 1'b1;
        tick();
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL wu1 got %h want 0000", pending); end
        tick();
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL wu2 got %h want 0000", pending); end
        tick();
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL wu3 got %h want 0000", pending); end
        cfg(8'd3, 1'b1, 2'b11);
        tick(); tick(); tick();
        checks++; if (pending !== 16'h0 || EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL no_spur got %h/%0d want 0000/0", pending, EIC_Interrupt); end
    endtask

    initial begin
        RESETn = 1'b0; signal = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mask = 1'b0; cfg_sense = '0;
        sw_we = 1'b0; sw_ch = '0; sw_val = 1'b0; EIC_IAck = 1'b0;
        test_reset();
        test_rise_ack();
        test_priority();
        test_level();
        test_preempt();
        test_ack_race();
        test_sw();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eic_vectored.md
# eic_vectored

Parametrised vectored external interrupt controller for the MIPSfpga+ system, successor to the fixed 63-channel EIC. It gives every channel run-time configurable sense mode and mask, latches edge events as pending, and arbitrates by fixed priority onto the MIPS EIC interface. It adds an acknowledge handshake that clears the serviced request, plus software set/clear. It sits between the external IRQ lines and the CPU's EIC port; register-bus glue is a separate block.

## Interface
- CHANNELS, 16, number of interrupt channels; legal range 1..255.
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- signal  in  CHANNELS  raw interrupt inputs.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  8  channel addressed by cfg_we; writes to cfg_ch >= CHANNELS are ignored.
- cfg_mask  in  1  mask value written (1 = enabled).
- cfg_sense  in  2  sense mode written: 00 low level, 01 any edge, 10 falling edge, 11 rising edge.
- sw_we  in  1  software pending-write strobe.
- sw_ch  in  8  channel addressed by sw_we; out-of-range writes are ignored.
- sw_val  in  1  pending value to force (1 = set, 0 = clear).
- EIC_IAck  in  1  CPU acknowledge of the presented interrupt, one-cycle pulse.
- pending  out  CHANNELS  per-channel pending flags, before masking.
- EIC_Interrupt  out  8  presented channel index + 1; 0 = none.
- EIC_Vector  out  6  EIC_Interrupt[5:0].
- EIC_Offset  out  17  constant 0.
- EIC_ShadowSet  out  4  constant 0.

## Operation
- Reset values:
  - mask = 0 and sense = 00 on every channel.
  - pending = 0, EIC_Interrupt = 0, FSM in IDLE.
  - Sense history cleared; sense warm-up counter = 2.
- Sense stage: a 2-bit history per channel, hist[1] older and hist[0] newest sample.
  - Event equations:
    - low = ~hist[1] & ~hist[0]
    - any = hist[1] ^ hist[0]
    - fall = hist[1] & ~hist[0]
    - rise = ~hist[1] & hist[0]
  - Events are forced to 0 while the warm-up counter is nonzero. The counter decrements once per cycle after reset.
- Pending update, per channel, evaluated each cycle in this order:
  - Level mode (00): pending = event. It is not latched, and ack has no effect.
  - Edge modes:
    - A sw_we write forces sw_val.
    - Otherwise an EIC_IAck that hits this channel clears the flag.
    - A new edge event ORs in last, so it always wins; no event is lost.
  - A cfg_we that changes a channel's sense mode clears that channel's pending flag in the same cycle.
- Arbitration: req = pending & mask. The winner is the highest-index set bit.
- FSM states:
  - IDLE: if req != 0, register EIC_Interrupt = winner + 1 and go to PRESENT.
  - PRESENT:
    - Re-arbitrate every cycle, so a higher-priority request pre-empts the presented one.
    - If req == 0, drive EIC_Interrupt = 0 and go to IDLE.
    - If EIC_IAck: clear the pending flag of the presented channel (edge modes only), drive EIC_Interrupt = 0, and go to HOLD.
  - HOLD: one cycle with output 0 so the cleared pending flag settles; then go to IDLE.
- EIC_IAck is ignored in IDLE and HOLD.
- An asynchronous reset asserted in any state returns all state to its reset values immediately.

## Timing
- A signal transition sampled at edge E0:
  - sets hist[0] at E0;
  - sets pending at E1;
  - appears on EIC_Interrupt at E2.
  - Input-to-vector latency is therefore 2 cycles; EIC_SYNC_EN adds 2.
- sw_we set: pending visible at the next edge; EIC_Interrupt follows one edge later.
- Ack at edge A:
  - pending is clear after A;
  - EIC_Interrupt is 0 after A and stays 0 through HOLD;
  - the next vector can appear at A+2 at the earliest.
- All outputs are registered except pending, which is a flop output, and EIC_Vector, EIC_Offset and EIC_ShadowSet, which are constant or bit-slices.

## Configuration
- EIC_SYNC_EN:
  - Defined: each signal bit passes through a 2-flop synchroniser, reset to 0, before hist. Latency +2 cycles; warm-up counter starts at 4.
  - Undefined: signal feeds hist directly, for inputs already synchronous to CLK.

## Test plan
- Reset, then CHANNELS=16, cfg ch3 = mask 1 / rise, pulse signal[3] 0→1 → EIC_Interrupt = 4 at E2; holds until ack; ack → 0 for 2 cycles, pending[3] = 0.
- ch2 rise and ch9 fall both pending → EIC_Interrupt = 10; ack → 3 presented at A+2; ack → 0.
- ch5 low level, mask 1, signal[5] = 0 → EIC_Interrupt = 6; ack does not clear it; raise signal[5] → 0 within 2 cycles.
- ch1 rise presented; ch7 event arrives → pre-empts, EIC_Interrupt = 8 next cycle; ch1 stays pending.
- Edge on ch4 in the same cycle as an ack of ch4 → pending[4] stays 1 and vector 5 re-presents after HOLD; sw_we ch4 val 0 → cleared.
- Rising signals held high through reset release → no pending during warm-up, no spurious events; RESETn asserted in PRESENT → outputs 0 immediately.
